mash_noise_cancel: RTL

//  Noise-cancellation/recombination network of the MASH sigma-delta DAC. It sits directly downstream
//  of the cascaded modulator stages (PART_1, PART_2, optional PART_3). Stage 1 output is delayed;

---
 rtl/mash_pkg.sv | 32 +++
 rtl/mash_diff_cell.sv | 55 +++++
 rtl/mash_noise_cancel.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mash_pkg.sv
// Shared constants and the saturation helper for the MASH recombination network.
package mash_pkg;

  localparam int unsigned MASH_W_IN  = 4;
  localparam int unsigned MAX_STAGES = 3;
  localparam int unsigned W_ACC      = MASH_W_IN + 3;

  typedef struct packed {
    logic signed [31:0] val;
    logic               clip;
  } sat_t;

  // Clip a signed value to the range of a signed 'width'-bit word; clip=1 when limited.
  function automatic sat_t sat_to(input int unsigned width, input logic signed [31:0] value);
    sat_t               r;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    r.clip = 1'b0;
    r.val  = value;
    if (value > hi) begin
      r.val  = hi;
      r.clip = 1'b1;
    end else if (value < lo) begin
      r.val  = lo;
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mash_diff_cell.sv
// Two-deep history of one stage output plus its 1st or 2nd difference.
// ORDER=2: x - 2*x_d1 + x_d2. ORDER=1: x - x_d1, or x_d1 - x_d2 when DELAYED=1.
module mash_diff_cell #(
  parameter int unsigned W_IN    = 4,
  parameter int unsigned W_ACC   = 7,
  parameter int unsigned ORDER   = 1,
  parameter int unsigned DELAYED = 0
) (
  input  logic                    clck,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W_IN-1:0]  x,
  output logic signed [W_ACC-1:0] diff
);

  logic signed [W_IN-1:0]  x_d1_q, x_d1_d;
  logic signed [W_IN-1:0]  x_d2_q, x_d2_d;
  logic signed [W_ACC-1:0] xe, e1, e2;

  // History shifts only on accepted samples; clr empties it.
  always_comb begin
    x_d1_d = x_d1_q;
    x_d2_d = x_d2_q;
    if (clr) begin
      x_d1_d = '0;
      x_d2_d = '0;
    end else if (en) begin
      x_d1_d = x;
      x_d2_d = x_d1_q;
    end
  end

  // History registers.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      x_d1_q <= '0;
      x_d2_q <= '0;
    end else begin
      x_d1_q <= x_d1_d;
      x_d2_q <= x_d2_d;
    end
  end

  // Sign-extend to the accumulator width and form the requested difference.
  always_comb begin
    xe = {{(W_ACC-W_IN){x[W_IN-1]}}, x};
    e1 = {{(W_ACC-W_IN){x_d1_q[W_IN-1]}}, x_d1_q};
    e2 = {{(W_ACC-W_IN){x_d2_q[W_IN-1]}}, x_d2_q};
    if (ORDER == 2)        diff = xe - (e1 <<< 1) + e2;
    else if (DELAYED != 0) diff = e1 - e2;
    else                   diff = xe - e1;
  end

endmodule

// File: rtl/mash_noise_cancel.sv
// MASH noise-cancellation network: delays stage 1, differences later stages,
// sums, saturates and registers a valid-qualified multi-level code.
module mash_noise_cancel
  import mash_pkg::*;
#(
  parameter int unsigned W_IN       = MASH_W_IN,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned W_OUT      = 7
) (
  input  logic                    clck,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [W_IN-1:0]  c1,
  input  logic signed [W_IN-1:0]  c2,
  input  logic signed [W_IN-1:0]  c3,
  output logic signed [W_OUT-1:0] y_out,
  output logic                    out_valid,
  output logic                    sat_flag
);

  localparam int unsigned W_SUM = W_IN + 3;

  if (NUM_STAGES < 2 || NUM_STAGES > MAX_STAGES) begin : g_bad_stages
    $error("mash_noise_cancel: NUM_STAGES must be 2 or 3");
  end

  logic                    accept;
  logic signed [W_IN-1:0]  c1_d1_q, c1_d1_d;
  logic signed [W_IN-1:0]  c1_d2_q, c1_d2_d;
  logic signed [W_SUM-1:0] d2_diff, d3_diff;
  logic signed [W_SUM-1:0] c1_sel, s;
  logic signed [31:0]      s32;
  sat_t                    sr;
  logic signed [W_OUT-1:0] y_q, y_d;
  logic                    vld_q, vld_d;
  logic                    sat_q, sat_d;
  logic [1:0]              prime_q, prime_d;

  assign accept = in_valid & ~clr;

  // In the 3-stage cascade the stage-2 difference is taken one sample late so it
  // lines up with the two-sample delay of stage 1 and the current 2nd difference of stage 3.
  if (NUM_STAGES == 3) begin : g_three
    mash_diff_cell #(.W_IN(W_IN), .W_ACC(W_SUM), .ORDER(1), .DELAYED(1)) u_c2 (
      .clck(clck), .rst(rst), .clr(clr), .en(accept), .x(c2), .diff(d2_diff)
    );
    mash_diff_cell #(.W_IN(W_IN), .W_ACC(W_SUM), .ORDER(2), .DELAYED(0)) u_c3 (
      .clck(clck), .rst(rst), .clr(clr), .en(accept), .x(c3), .diff(d3_diff)
    );
  end else begin : g_two
    mash_diff_cell #(.W_IN(W_IN), .W_ACC(W_SUM), .ORDER(1), .DELAYED(0)) u_c2 (
      .clck(clck), .rst(rst), .clr(clr), .en(accept), .x(c2), .diff(d2_diff)
    );
    assign d3_diff = '0;
  end

  // Stage-1 delay line next state.
  always_comb begin
    c1_d1_d = c1_d1_q;
    c1_d2_d = c1_d2_q;
    if (clr) begin
      c1_d1_d = '0;
      c1_d2_d = '0;
    end else if (in_valid) begin
      c1_d1_d = c1;
      c1_d2_d = c1_d1_q;
    end
  end

  // Adder tree and saturation.
  always_comb begin
    if (NUM_STAGES == 3) c1_sel = {{(W_SUM-W_IN){c1_d2_q[W_IN-1]}}, c1_d2_q};
    else                 c1_sel = {{(W_SUM-W_IN){c1_d1_q[W_IN-1]}}, c1_d1_q};
    s   = c1_sel + d2_diff + d3_diff;
    s32 = {{(32-W_SUM){s[W_SUM-1]}}, s};
    sr  = sat_to(W_OUT, s32);
  end

  // Output, sticky flag and priming counter next state.
  always_comb begin
    y_d     = y_q;
    vld_d   = 1'b0;
    sat_d   = sat_q;
    prime_d = prime_q;
    if (clr) begin
      y_d     = '0;
      sat_d   = 1'b0;
      prime_d = '0;
    end else if (in_valid) begin
      y_d   = sr.val[W_OUT-1:0];
      vld_d = (prime_q == 2'(NUM_STAGES - 1));
      sat_d = sat_q | sr.clip;
      if (prime_q != 2'(NUM_STAGES - 1)) prime_d = prime_q + 2'd1;
    end
  end

  // State registers.
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      c1_d1_q <= '0;
      c1_d2_q <= '0;
      y_q     <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      c1_d1_q <= c1_d1_d;
      c1_d2_q <= c1_d2_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
      prime_q <= prime_d;
    end
  end

  assign y_out     = y_q;
  assign out_valid = vld_q;
  assign sat_flag  = sat_q;

endmodule
